// File: rtl/ssp_tx_fifo_pkg.sv
// Shared SSP constants used by both the transmit and receive FIFOs.
package ssp_tx_fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: APB host pushes bytes, the shift logic pops them.
// First-word fall-through head, full flag (SSPTXINTR), sticky overflow.
module ssp_tx_fifo
  import ssp_tx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_Width = FIFO_WIDTH,
  parameter int unsigned FIFO_Depth = FIFO_DEPTH
) (
  input  logic                          PCLK,
  input  logic                          CLEAR,
  input  logic                          PSEL,
  input  logic                          PWRITE,
  input  logic [FIFO_Width-1:0]         PWDATA,
  input  logic                          tx_pop,
  output logic [FIFO_Width-1:0]         TxData,
  output logic                          tx_valid,
  output logic                          SSPTXINTR,
  output logic                          fifo_empty,
  output logic                          tx_overflow,
  output logic [$clog2(FIFO_Depth):0]   level
);

  localparam int unsigned PtrW = $clog2(FIFO_Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [FIFO_Width-1:0] mem_q [FIFO_Depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q,  level_d;
  logic            ovf_q,    ovf_d;

  logic full, empty, wr_req, push, pop;

  assign full   = (level_q == LvlW'(FIFO_Depth));
  assign empty  = (level_q == '0);
  assign wr_req = PSEL && PWRITE;
  assign push   = wr_req && !full;
  assign pop    = tx_pop && !empty;

  // Next-state for pointers, occupancy and sticky overflow (pre-edge fullness gates push).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
    if (wr_req && full) begin
      ovf_d = 1'b1;
    end
  end

  // Control state register; CLEAR discards all queued entries immediately.
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= PWDATA;
    end
  end

  // Output decode from registered level and read pointer; head forced to 0 when empty.
  always_comb begin
    tx_valid    = !empty;
    fifo_empty  = empty;
    SSPTXINTR   = full;
    tx_overflow = ovf_q;
    level       = level_q;
    TxData      = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Directed self-checking bench for ssp_tx_fifo.
module tb_ssp_tx_fifo;

  logic       PCLK = 1'b0;
  logic       clk_en = 1'b0;
  logic       CLEAR;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       tx_pop;
  logic [7:0] TxData;
  logic       tx_valid;
  logic       SSPTXINTR;
  logic       fifo_empty;
  logic       tx_overflow;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  ssp_tx_fifo #(.FIFO_Width(8), .FIFO_Depth(4)) dut (
    .PCLK        (PCLK),
    .CLEAR       (CLEAR),
    .PSEL        (PSEL),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .tx_pop      (tx_pop),
    .TxData      (TxData),
    .tx_valid    (tx_valid),
    .SSPTXINTR   (SSPTXINTR),
    .fifo_empty  (fifo_empty),
    .tx_overflow (tx_overflow),
    .level       (level)
  );

  always #5 if (clk_en) PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given request; inputs are released 1ns after the edge.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
    PSEL   = wr;
    PWRITE = wr;
    PWDATA = d;
    tx_pop = rd;
    @(posedge PCLK);
    #1;
    PSEL   = 1'b0;
    PWRITE = 1'b0;
    PWDATA = 8'h00;
    tx_pop = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] lvl, input logic [7:0] head,
                           input logic full, input logic ovf);
    chk({tag, "_level"}, 32'(level), 32'(lvl));
    chk({tag, "_txdata"}, 32'(TxData), 32'(head));
    chk({tag, "_valid"}, 32'(tx_valid), 32'(lvl != 0));
    chk({tag, "_empty"}, 32'(fifo_empty), 32'(lvl == 0));
    chk({tag, "_full"}, 32'(SSPTXINTR), 32'(full));
    chk({tag, "_ovf"}, 32'(tx_overflow), 32'(ovf));
  endtask

  initial begin
    PSEL = 1'b0; PWRITE = 1'b0; PWDATA = 8'h00; tx_pop = 1'b0;

    // Reset with no clock running
    CLEAR = 1'b1;
    #5;
    chk_state("reset", 3'd0, 8'h00, 1'b0, 1'b0);
    CLEAR = 1'b0;
    #2;
    clk_en = 1'b1;
    @(posedge PCLK); #1;

    // Fill and drain
    cycle(1'b1, 8'hA1, 1'b0);
    chk_state("push1", 3'd1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b1, 8'hD4, 1'b0);
    chk_state("full4", 3'd4, 8'hA1, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("drain1", 3'd3, 8'hB2, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("drain2", 3'd2, 8'hC3, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("drain3", 3'd1, 8'hD4, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("drain4", 3'd0, 8'h00, 1'b0, 1'b0);

    // Overflow while full: write dropped, sticky flag
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    chk_state("ovf_write", 3'd4, 8'h10, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("ovf_drain_data", 32'(TxData), 32'h10 + 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("ovf_drained", 3'd0, 8'h00, 1'b0, 1'b1);

    // Write while full with a simultaneous pop: push refused, pop proceeds
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0);
    cycle(1'b1, 8'hEF, 1'b1);
    chk_state("full_wr_pop", 3'd3, 8'h21, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("fwp_d2", 32'(TxData), 32'h22);
    cycle(1'b0, 8'h00, 1'b1);
    chk("fwp_d3", 32'(TxData), 32'h23);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("fwp_empty", 3'd0, 8'h00, 1'b0, 1'b1);

    // CLEAR between edges releases the sticky overflow
    #2 CLEAR = 1'b1;
    #1 chk("ovf_cleared", 32'(tx_overflow), 32'h0);
    #1 CLEAR = 1'b0;
    @(posedge PCLK); #1;

    // Simultaneous push and pop at level 2
    cycle(1'b1, 8'h30, 1'b0);
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b1, 8'h55, 1'b1);
    chk_state("pushpop_l2", 3'd2, 8'h31, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("pp_next55", 3'd1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("pp_empty", 3'd0, 8'h00, 1'b0, 1'b0);

    // Wrap-around: ten push/pop pairs
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      chk("wrap_head", 32'(TxData), 32'(i));
      chk("wrap_lvl1", 32'(level), 32'd1);
      cycle(1'b0, 8'h00, 1'b1);
      chk("wrap_lvl0", 32'(level), 32'd0);
    end

    // Pop while empty is ignored
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("empty_pop", 3'd0, 8'h00, 1'b0, 1'b0);

    // Push and pop together on an empty FIFO: push stored, pop ignored
    cycle(1'b1, 8'h66, 1'b1);
    chk_state("empty_pushpop", 3'd1, 8'h66, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk_state("epp_drain", 3'd0, 8'h00, 1'b0, 1'b0);

    // Mid-operation CLEAR at level 3
    cycle(1'b1, 8'h71, 1'b0);
    cycle(1'b1, 8'h72, 1'b0);
    cycle(1'b1, 8'h73, 1'b0);
    chk_state("pre_clear", 3'd3, 8'h71, 1'b0, 1'b0);
    #2 CLEAR = 1'b1;
    #1 chk_state("mid_clear", 3'd0, 8'h00, 1'b0, 1'b0);
    #1 CLEAR = 1'b0;
    cycle(1'b1, 8'h7F, 1'b0);
    chk_state("post_clear", 3'd1, 8'h7F, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
